// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART: register word offsets, field bit positions
// and the TX/RX state encodings.
package apb_uart_pkg;
    localparam int BAUD_W = 16;

    // Word offsets, i.e. PADDR[7:2]
    localparam logic [5:0] OFF_DATA   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_CTRL   = 6'h02;
    localparam logic [5:0] OFF_BAUD   = 6'h03;

    localparam int ST_TX_BUSY  = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_FERR     = 4;

    localparam int CT_TX_EN  = 0;
    localparam int CT_RX_EN  = 1;
    localparam int CT_TX_IRQ = 2;
    localparam int CT_RX_IRQ = 3;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver, 16 ticks per bit: synchronizes RXD, centres on the start bit and
// pulses byte_valid or frame_err when the stop bit is sampled.
module uart_rx
    import apb_uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       tick,
    input  logic       rx_en,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    logic      sync1_q, sync2_q, prev_q;
    rx_state_t state_q, state_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (!rx_en) begin
            state_d = RX_IDLE;
            tcnt_d  = '0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_d = RX_START;
                        tcnt_d  = '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        tcnt_d = tcnt_q + 4'd1;
                        // Mid start bit: a high line here was only a glitch
                        if (tcnt_q == 4'd7) begin
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                            state_d = sync2_q ? RX_IDLE : RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        tcnt_d = tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            shift_d = {sync2_q, shift_q[7:1]};
                            bcnt_d  = bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        tcnt_d = tcnt_q + 4'd1;
                        if (tcnt_q == 4'd15) begin
                            state_d    = RX_IDLE;
                            byte_valid = sync2_q;
                            frame_err  = !sync2_q;
                        end
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign rx_byte = shift_q;
endmodule

// File: rtl/apb_uart.sv
// APB slave UART: register file, APB handshake, baud tick generator and TX FSM;
// reception is delegated to uart_rx.
module apb_uart
    import apb_uart_pkg::*;
#(
    parameter int              ADDR_WIDTH  = 32,
    parameter int              DATA_WIDTH  = 32,
    parameter logic [BAUD_W-1:0] BAUDDIV_RST = 16'd26
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  RXD,
    output logic                  TXD,
    output logic                  IRQ
);
    tx_state_t   tx_state_q, tx_state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [BAUD_W-1:0] baud_q, baud_d, bcnt_q, bcnt_d;
    logic [7:0]  thr_q, thr_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
    logic [3:0]  tx_tcnt_q, tx_tcnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_full_q, tx_full_d, txd_q, txd_d, done_q, done_d;
    logic        rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic [5:0]  offs;
    logic        access, fire, rd_data, tick, baud_run, tx_busy, load_thr;
    logic [7:0]  rx_byte;
    logic        rx_bv, rx_fe;
    logic [15:0] rd_field;
    logic        unused_bits;

    assign offs    = PADDR[7:2];
    assign access  = PSEL & PENABLE;
    assign tx_busy = (tx_state_q != TX_IDLE);
    assign PREADY  = !(access && !done_q && PWRITE && offs == OFF_DATA &&
                       tx_full_q && ctrl_q[CT_TX_EN]);
    // done_q keeps a stretched access phase from repeating side effects
    assign fire    = access & PREADY & !done_q;
    assign done_d  = PENABLE & (done_q | (access & PREADY));
    assign rd_data = fire && !PWRITE && offs == OFF_DATA;
    assign unused_bits = ^{PADDR[ADDR_WIDTH-1:8], PADDR[1:0], PWDATA[DATA_WIDTH-1:16]};

    // Keep ticking while a frame drains so clearing the enables cannot stall TX
    assign baud_run = ctrl_q[CT_TX_EN] | ctrl_q[CT_RX_EN] | tx_busy;
    assign tick     = baud_run && (bcnt_q == baud_q);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state_q <= TX_IDLE;
            ctrl_q     <= '0;
            baud_q     <= BAUDDIV_RST;
            bcnt_q     <= '0;
            thr_q      <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_full_q  <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            bcnt_q     <= bcnt_d;
            thr_q      <= thr_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_full_q  <= tx_full_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        bcnt_d = '0;
        if (!(fire && PWRITE && offs == OFF_BAUD) && baud_run && !tick)
            bcnt_d = bcnt_q + 16'd1;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        txd_d      = txd_q;
        load_thr   = 1'b0;
        if (tick) begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_full_q && ctrl_q[CT_TX_EN]) begin
                        tx_state_d = TX_START;
                        tx_shift_d = thr_q;
                        tx_tcnt_d  = '0;
                        txd_d      = 1'b0;
                        load_thr   = 1'b1;
                    end
                end
                TX_START: begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == 4'd15) begin
                        tx_state_d = TX_DATA;
                        tx_bit_d   = '0;
                        txd_d      = tx_shift_q[0];
                    end
                end
                TX_DATA: begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == 4'd15) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = TX_STOP;
                            txd_d      = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            txd_d      = tx_shift_q[1];
                        end
                    end
                end
                TX_STOP: begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == 4'd15) begin
                        // A waiting byte goes straight into its start bit
                        if (tx_full_q && ctrl_q[CT_TX_EN]) begin
                            tx_state_d = TX_START;
                            tx_shift_d = thr_q;
                            txd_d      = 1'b0;
                            load_thr   = 1'b1;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        thr_d      = thr_q;
        tx_full_d  = tx_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        ferr_d     = ferr_q;
        if (fire && PWRITE) begin
            case (offs)
                OFF_DATA: begin
                    if (!tx_full_q) begin
                        thr_d     = PWDATA[7:0];
                        tx_full_d = 1'b1;
                    end
                end
                OFF_STATUS: begin
                    if (PWDATA[ST_RX_OVR]) ovr_d  = 1'b0;
                    if (PWDATA[ST_FERR])   ferr_d = 1'b0;
                end
                OFF_CTRL: ctrl_d = PWDATA[3:0];
                OFF_BAUD: baud_d = PWDATA[BAUD_W-1:0];
                default: ;
            endcase
        end
        if (rd_data)  rx_valid_d = 1'b0;
        if (load_thr) tx_full_d  = 1'b0;
        // Hardware sets are applied last so they win over W1C and read-clear
        if (rx_bv) begin
            if (!rx_valid_q || rd_data) begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (rx_fe) ferr_d = 1'b1;
    end

    always_comb begin
        rd_field = '0;
        case (offs)
            OFF_DATA:   rd_field = {8'h00, rx_data_q};
            OFF_STATUS: rd_field = {11'h000, ferr_q, ovr_q, rx_valid_q, tx_full_q, tx_busy};
            OFF_CTRL:   rd_field = {12'h000, ctrl_q};
            OFF_BAUD:   rd_field = baud_q;
            default:    rd_field = '0;
        endcase
        PRDATA = (access && !PWRITE) ? DATA_WIDTH'(rd_field) : '0;
    end

    assign TXD = txd_q;
    assign IRQ = (ctrl_q[CT_TX_IRQ] & !tx_full_q) |
                 (ctrl_q[CT_RX_IRQ] & (rx_valid_q | ovr_q | ferr_q));

    uart_rx u_rx (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .rxd        (RXD),
        .tick       (tick),
        .rx_en      (ctrl_q[CT_RX_EN]),
        .rx_byte    (rx_byte),
        .byte_valid (rx_bv),
        .frame_err  (rx_fe)
    );
endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for apb_uart: register vector table, then TX waveform, wait-state,
// RX status, glitch, stretched-access and mid-frame reset sequences.
module tb_apb_uart;
    logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE, PREADY, RXD, TXD, IRQ;
    logic [31:0] PADDR, PWDATA, PRDATA;
    int tests = 0;
    int fails = 0;

    apb_uart dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY),
        .PRDATA(PRDATA), .RXD(RXD), .TXD(TXD), .IRQ(IRQ)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output int waits);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1; waits = 0;
        #1;
        while (!PREADY && waits < 1000) begin
            @(negedge PCLK); #1; waits++;
        end
        if (waits >= 1000) chk("apb_wr_timeout", {31'b0, PREADY}, 32'd1);
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1;
        #1 d = PRDATA;
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int w;
        apb_wr(a, d, w);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK); RXD = f[i];
            repeat (15) @(negedge PCLK);
        end
        @(negedge PCLK); RXD = 1'b1;
    endtask

    // Waits for the start bit, then compares TXD every cycle against the ideal frames
    task automatic mon_tx(input logic [23:0] bytes, input int nbytes, input int bitlen,
                          input string nm);
        int t, errs;
        t = 0;
        while (TXD !== 1'b0 && t < 4000) begin
            @(negedge PCLK); t++;
        end
        if (t >= 4000) begin
            chk({nm, "_start"}, {31'b0, TXD}, 32'd0);
        end else begin
            errs = 0;
            for (int k = 0; k < nbytes * 10 * bitlen; k++) begin
                int fr, bi;
                logic [7:0] by;
                logic e;
                fr = k / (10 * bitlen);
                bi = (k / bitlen) % 10;
                by = bytes[fr*8 +: 8];
                e  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : by[bi-1];
                if (TXD !== e) errs++;
                @(negedge PCLK);
            end
            chk(nm, errs, 0);
        end
    endtask

    vec_t vt[16];
    logic [31:0] d, held;
    int waits;

    initial begin
        vt[0]  = '{1'b0, 32'h04, 32'h0, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 32'h08, 32'h0, 32'h0, 1'b0};
        vt[2]  = '{1'b0, 32'h0C, 32'h0, 32'd26, 1'b0};
        vt[3]  = '{1'b0, 32'h00, 32'h0, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
        vt[5]  = '{1'b1, 32'h0C, 32'hFFFF1234, 32'h0, 1'b0};
        vt[6]  = '{1'b0, 32'h1000000C, 32'h0, 32'h1234, 1'b0};
        vt[7]  = '{1'b1, 32'h10, 32'hFF, 32'h0, 1'b0};
        vt[8]  = '{1'b0, 32'h10, 32'h0, 32'h0, 1'b0};
        vt[9]  = '{1'b1, 32'h08, 32'hC, 32'h0, 1'b1};
        vt[10] = '{1'b0, 32'h08, 32'h0, 32'hC, 1'b1};
        vt[11] = '{1'b1, 32'h04, 32'h1F, 32'h0, 1'b1};
        vt[12] = '{1'b0, 32'h04, 32'h0, 32'h0, 1'b1};
        vt[13] = '{1'b1, 32'h08, 32'h0, 32'h0, 1'b0};
        vt[14] = '{1'b1, 32'h0C, 32'h0, 32'h0, 1'b0};
        vt[15] = '{1'b0, 32'h0C, 32'h0, 32'h0, 1'b0};

        PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; RXD = 1;
        repeat (3) @(negedge PCLK);
        chk("rst_txd", {31'b0, TXD}, 32'd1);
        chk("rst_pready", {31'b0, PREADY}, 32'd1);
        chk("rst_irq", {31'b0, IRQ}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        PRESETn = 1;
        repeat (2) @(negedge PCLK);

        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) begin
                apb_wr(vt[i].addr, vt[i].wdata, waits);
            end else begin
                apb_rd(vt[i].addr, d);
                chk($sformatf("vec%0d_rdata", i), d, vt[i].exp);
            end
            chk($sformatf("vec%0d_irq", i), {31'b0, IRQ}, {31'b0, vt[i].exp_irq});
        end

        // Setup phase only: PRDATA must stay 0
        @(negedge PCLK); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h0C;
        #1 chk("prdata_setup_zero", PRDATA, 32'd0);
        @(negedge PCLK); PSEL = 0;

        // Single frame, 16 cycles per bit
        wr(32'h08, 32'h1);
        fork
            mon_tx(24'hA5, 1, 16, "tx_a5_wave");
            begin
                wr(32'h00, 32'hA5);
                rd_chk("tx_a5_busy", 32'h04, 32'h1);
            end
        join
        repeat (4) @(negedge PCLK);
        rd_chk("tx_a5_idle", 32'h04, 32'h0);

        // Back-to-back frames with a stalled third write
        fork
            mon_tx({8'h33, 8'h22, 8'h11}, 3, 16, "tx_b2b_wave");
            begin
                wr(32'h00, 32'h11);
                wr(32'h00, 32'h22);
                rd_chk("tx_b2b_full", 32'h04, 32'h3);
                apb_wr(32'h00, 32'h33, waits);
                chk("tx_b2b_waits_gt100", {31'b0, (waits > 100)}, 32'd1);
                chk("tx_b2b_waits_lt170", {31'b0, (waits < 170)}, 32'd1);
            end
        join
        repeat (4) @(negedge PCLK);
        rd_chk("tx_b2b_idle", 32'h04, 32'h0);

        // BAUDDIV=1 doubles the bit time
        wr(32'h0C, 32'h1);
        fork
            mon_tx(24'h5A, 1, 32, "tx_div1_wave");
            wr(32'h00, 32'h5A);
        join
        repeat (4) @(negedge PCLK);

        // Receive path, rx_en + rx_irq_en
        wr(32'h0C, 32'h0);
        wr(32'h08, 32'hA);
        chk("rx_irq_idle", {31'b0, IRQ}, 32'd0);
        send_rx(8'h3C, 1'b1);
        rd_chk("rx_valid", 32'h04, 32'h4);
        chk("rx_irq_valid", {31'b0, IRQ}, 32'd1);
        send_rx(8'h5A, 1'b1);
        rd_chk("rx_overrun", 32'h04, 32'hC);
        rd_chk("rx_data_kept", 32'h00, 32'h3C);
        rd_chk("rx_valid_cleared", 32'h04, 32'h8);
        wr(32'h04, 32'h08);
        rd_chk("rx_ovr_w1c", 32'h04, 32'h0);
        chk("rx_irq_clear", {31'b0, IRQ}, 32'd0);

        send_rx(8'h42, 1'b1);
        send_rx(8'h77, 1'b0);
        rd_chk("rx_frame_err", 32'h04, 32'h14);
        wr(32'h04, 32'h10);
        rd_chk("rx_ferr_w1c", 32'h04, 32'h4);
        rd_chk("rx_data_after_ferr", 32'h00, 32'h42);
        rd_chk("rx_empty", 32'h04, 32'h0);

        @(negedge PCLK); RXD = 1'b0;
        repeat (4) @(negedge PCLK);
        RXD = 1'b1;
        repeat (200) @(negedge PCLK);
        rd_chk("rx_glitch_reject", 32'h04, 32'h0);
        send_rx(8'h81, 1'b1);
        rd_chk("rx_after_glitch", 32'h00, 32'h81);

        // Stretched DATA read: a byte landing during the hold must survive
        send_rx(8'hA1, 1'b1);
        fork
            send_rx(8'hB2, 1'b1);
            begin
                repeat (150) @(negedge PCLK);
                PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 32'h00;
                @(negedge PCLK);
                PENABLE = 1;
                #1 held = PRDATA;
                repeat (8) @(negedge PCLK);
                PSEL = 0; PENABLE = 0;
            end
        join
        chk("rx_hold_rdata", held, 32'hA1);
        rd_chk("rx_hold_status", 32'h04, 32'h4);
        rd_chk("rx_hold_next", 32'h00, 32'hB2);

        // Reset in the middle of a frame
        wr(32'h08, 32'h1);
        wr(32'h00, 32'h00);
        repeat (20) @(negedge PCLK);
        chk("mid_frame_txd_low", {31'b0, TXD}, 32'd0);
        PRESETn = 0;
        #1 chk("mid_frame_rst_txd", {31'b0, TXD}, 32'd1);
        repeat (2) @(negedge PCLK);
        PRESETn = 1;
        rd_chk("post_rst_status", 32'h04, 32'h0);
        rd_chk("post_rst_ctrl", 32'h08, 32'h0);
        rd_chk("post_rst_baud", 32'h0C, 32'd26);
        repeat (40) @(negedge PCLK);
        chk("post_rst_txd", {31'b0, TXD}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
